// File: rtl/regfile_debug_dumper_if.sv
// regfile_debug_dumper_if
//   Bundles the dumper's control handshake, the register-file debug read
//   port and the serial line into one interface.
//   Signals:
//     start    - one-cycle dump request            (to dumper)
//     busy     - dump in progress                  (from dumper)
//     done     - one-cycle end-of-dump pulse       (from dumper)
//     dbg_addr - debug read address, 5 bits       (from dumper)
//     dbg_clk  - debug read clock pulse            (from dumper)
//     dbg_data - debug read data, 32 bits         (to dumper)
//     tx       - 8N1 serial output, idle high      (from dumper)
//   Modports: master = dumper side, slave = lab top / register file side.
interface regfile_debug_dumper_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  dbg_addr;
  logic        dbg_clk;
  logic [31:0] dbg_data;
  logic        tx;

  modport master (
    input  start, dbg_data,
    output busy, done, dbg_addr, dbg_clk, tx
  );

  modport slave (
    output start, dbg_data,
    input  busy, done, dbg_addr, dbg_clk, tx
  );
endinterface

// File: rtl/regfile_debug_dumper.sv
// regfile_debug_dumper
//   Walks register addresses 0..NUM_REGS-1 over the register file's debug
//   port and sends every 32-bit word MSB-first as 8N1 serial bytes.
//   Parameters:
//     CLKS_PER_BIT - clock cycles per serial bit (>= 2)
//     NUM_REGS     - registers dumped from address 0 (1..32)
//   Ports:
//     clock - system clock, posedge
//     reset - asynchronous, active-high; aborts a dump with no done pulse
//     bus   - regfile_debug_dumper_if.master (start/busy/done, dbg_*, tx)
//   Build option:
//     DUMP_HEADER_EN - when defined, each register is preceded by a header
//                      byte {3'b000, addr}, giving 5 bytes per register.
module regfile_debug_dumper #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_REGS     = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  regfile_debug_dumper_if.master        bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef DUMP_HEADER_EN
  localparam int BIW = 3;
  localparam logic [BIW-1:0] LAST_BYTE = 3'd4;
`else
  localparam int BIW = 2;
  localparam logic [BIW-1:0] LAST_BYTE = 2'd3;
`endif
  localparam logic [4:0]    LAST_ADDR = 5'(NUM_REGS - 1);
  localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_CAPT, S_SEND, S_NEXT
  } state_e;

  state_e          state_q;
  logic [4:0]      addr_q;
  logic            dbg_clk_q;
  logic [31:0]     word_q;
  logic [BIW-1:0]  byte_idx_q;
  logic [3:0]      bit_idx_q;   // 0 = start, 1..8 = data, 9 = stop
  logic [CW-1:0]   clk_cnt_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
  logic [7:0]      cur_byte;

  // Byte currently on the wire, selected by byte_idx.
  always_comb begin
    cur_byte = 8'h00;
`ifdef DUMP_HEADER_EN
    case (byte_idx_q)
      3'd0:    cur_byte = {3'b000, addr_q};
      3'd1:    cur_byte = word_q[31:24];
      3'd2:    cur_byte = word_q[23:16];
      3'd3:    cur_byte = word_q[15:8];
      3'd4:    cur_byte = word_q[7:0];
      default: cur_byte = 8'h00;
    endcase
`else
    case (byte_idx_q)
      2'd0:    cur_byte = word_q[31:24];
      2'd1:    cur_byte = word_q[23:16];
      2'd2:    cur_byte = word_q[15:8];
      default: cur_byte = word_q[7:0];
    endcase
`endif
  end

  // tx is updated on the same edge that moves the bit counter, so the
  // value for the bit being entered is chosen from the bit being left.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      dbg_clk_q  <= 1'b0;
      word_q     <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      clk_cnt_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            addr_q    <= '0;
            busy_q    <= 1'b1;
            dbg_clk_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          dbg_clk_q <= 1'b0;
          state_q   <= S_WAIT;
        end
        S_WAIT: state_q <= S_CAPT;
        S_CAPT: begin
          word_q     <= bus.dbg_data;
          byte_idx_q <= '0;
          bit_idx_q  <= '0;
          clk_cnt_q  <= '0;
          tx_q       <= 1'b0;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (clk_cnt_q != LAST_CLK) begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end else begin
            clk_cnt_q <= '0;
            if (bit_idx_q != 4'd9) begin
              bit_idx_q <= bit_idx_q + 4'd1;
              tx_q      <= (bit_idx_q == 4'd8) ? 1'b1 : cur_byte[bit_idx_q[2:0]];
            end else if (byte_idx_q != LAST_BYTE) begin
              byte_idx_q <= byte_idx_q + 1'b1;
              bit_idx_q  <= '0;
              tx_q       <= 1'b0;
            end else begin
              tx_q    <= 1'b1;
              done_q  <= (addr_q == LAST_ADDR);
              state_q <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          done_q <= 1'b0;
          if (addr_q == LAST_ADDR) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            addr_q    <= addr_q + 5'd1;
            dbg_clk_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dbg_addr = addr_q;
  assign bus.dbg_clk  = dbg_clk_q;
  assign bus.tx       = tx_q;

endmodule
